// File: rtl/de_scoreboard_ctrl.sv
// Decode-stage issue controller: per-register in-flight write scoreboard,
// control-flow pending flag, and DE stall/issue/flush qualifiers.
module de_scoreboard_ctrl #(
    parameter int NREGS     = 32,
    parameter int REGNOBITS = 5,
    parameter int CNTBITS   = 2,
    parameter int PERFBITS  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 de_valid,
    input  logic [REGNOBITS-1:0] de_rs1,
    input  logic                 de_rs1_read,
    input  logic [REGNOBITS-1:0] de_rs2,
    input  logic                 de_rs2_read,
    input  logic [REGNOBITS-1:0] de_rd,
    input  logic                 de_wr_reg,
    input  logic                 de_is_ctrl,
    input  logic                 wb_wr_reg,
    input  logic [REGNOBITS-1:0] wb_rd,
    input  logic                 br_resolve,
    input  logic                 br_mispredict,
    output logic                 stall_DE,
    output logic                 issue_DE,
    output logic                 flush_DE,
    output logic [NREGS-1:0]     busy_regs,
    output logic                 br_pending,
    output logic [PERFBITS-1:0]  stall_count,
    output logic                 sb_error
);

    localparam logic [CNTBITS-1:0]  CNT_MAX  = {CNTBITS{1'b1}};
    localparam logic [PERFBITS-1:0] PERF_MAX = {PERFBITS{1'b1}};

    logic [CNTBITS-1:0] cnt [NREGS];
    logic [CNTBITS-1:0] eff [NREGS];
    logic [NREGS-1:0]   dec;
    logic [NREGS-1:0]   inc;
    logic               rel_err;
    logic               raw_hz;
    logic               cap_hz;

    // A WB in the same cycle satisfies the read since the RF writes on negedge.
    always_comb begin
        rel_err = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            dec[i] = 1'b0;
            if (i != 0 && wb_wr_reg && wb_rd == REGNOBITS'(i)) begin
                dec[i]  = (cnt[i] != '0);
                rel_err = (cnt[i] == '0);
            end
            eff[i] = cnt[i] - CNTBITS'(dec[i]);
        end
    end

    always_comb begin
        raw_hz = 1'b0;
        if (de_rs1_read && de_rs1 != '0 && eff[de_rs1] != '0)
            raw_hz = 1'b1;
        if (de_rs2_read && de_rs2 != '0 && eff[de_rs2] != '0)
            raw_hz = 1'b1;
        cap_hz = de_wr_reg && de_rd != '0 && eff[de_rd] == CNT_MAX;
    end

    assign flush_DE = br_resolve & br_mispredict;
    assign stall_DE = de_valid & ~flush_DE & (raw_hz | cap_hz | br_pending);
    assign issue_DE = de_valid & ~stall_DE & ~flush_DE;

    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            inc[i] = (i != 0) && issue_DE && de_wr_reg
                     && de_rd == REGNOBITS'(i);
            busy_regs[i] = (cnt[i] != '0);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++)
                cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++)
                cnt[i] <= cnt[i] + CNTBITS'(inc[i]) - CNTBITS'(dec[i]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            br_pending  <= 1'b0;
            stall_count <= '0;
            sb_error    <= 1'b0;
        end else begin
            if (issue_DE && de_is_ctrl)
                br_pending <= 1'b1;
            else if (br_resolve)
                br_pending <= 1'b0;
            if (stall_DE && stall_count != PERF_MAX)
                stall_count <= stall_count + 1'b1;
            if (rel_err)
                sb_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_de_scoreboard_ctrl.sv
// Randomized bench for de_scoreboard_ctrl against a pending-write-count
// reference model, with directed error and async-reset checks.
module tb_de_scoreboard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        de_valid;
    logic [4:0]  de_rs1;
    logic        de_rs1_read;
    logic [4:0]  de_rs2;
    logic        de_rs2_read;
    logic [4:0]  de_rd;
    logic        de_wr_reg;
    logic        de_is_ctrl;
    logic        wb_wr_reg;
    logic [4:0]  wb_rd;
    logic        br_resolve;
    logic        br_mispredict;
    logic        stall_DE;
    logic        issue_DE;
    logic        flush_DE;
    logic [31:0] busy_regs;
    logic        br_pending;
    logic [15:0] stall_count;
    logic        sb_error;

    int checks   = 0;
    int failures = 0;

    int cnt_m [32];
    int pend_m;
    int err_m;
    int sc_m;
    bit exp_stall, exp_issue, exp_flush;

    de_scoreboard_ctrl dut (
        .clk(clk), .reset(reset),
        .de_valid(de_valid),
        .de_rs1(de_rs1), .de_rs1_read(de_rs1_read),
        .de_rs2(de_rs2), .de_rs2_read(de_rs2_read),
        .de_rd(de_rd), .de_wr_reg(de_wr_reg),
        .de_is_ctrl(de_is_ctrl),
        .wb_wr_reg(wb_wr_reg), .wb_rd(wb_rd),
        .br_resolve(br_resolve), .br_mispredict(br_mispredict),
        .stall_DE(stall_DE), .issue_DE(issue_DE), .flush_DE(flush_DE),
        .busy_regs(busy_regs), .br_pending(br_pending),
        .stall_count(stall_count), .sb_error(sb_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) cnt_m[i] = 0;
        pend_m = 0;
        err_m  = 0;
        sc_m   = 0;
    endtask

    task automatic idle_inputs();
        de_valid = 0; de_rs1 = 0; de_rs1_read = 0;
        de_rs2 = 0; de_rs2_read = 0; de_rd = 0; de_wr_reg = 0;
        de_is_ctrl = 0; wb_wr_reg = 0; wb_rd = 0;
        br_resolve = 0; br_mispredict = 0;
    endtask

    function automatic bit releases(int r);
        return wb_wr_reg && int'(wb_rd) == r && r != 0 && cnt_m[r] > 0;
    endfunction

    function automatic int pending_after_wb(int r);
        return cnt_m[r] - (releases(r) ? 1 : 0);
    endfunction

    task automatic predict();
        bit raw, cap;
        raw = (de_rs1_read && de_rs1 != 0 && pending_after_wb(int'(de_rs1)) > 0)
           || (de_rs2_read && de_rs2 != 0 && pending_after_wb(int'(de_rs2)) > 0);
        cap = de_wr_reg && de_rd != 0 && pending_after_wb(int'(de_rd)) == 3;
        exp_flush = br_resolve && br_mispredict;
        exp_stall = de_valid && !exp_flush && (raw || cap || pend_m != 0);
        exp_issue = de_valid && !exp_stall && !exp_flush;
    endtask

    function automatic logic [31:0] busy_m();
        logic [31:0] b;
        for (int i = 0; i < 32; i++) b[i] = cnt_m[i] > 0;
        return b;
    endfunction

    task automatic check_state(input string pfx);
        chk({pfx, "_busy"}, busy_regs, busy_m());
        chk({pfx, "_pend"}, 32'(br_pending), 32'(pend_m));
        chk({pfx, "_scnt"}, 32'(stall_count), 32'(sc_m));
        chk({pfx, "_err"}, 32'(sb_error), 32'(err_m));
    endtask

    task automatic check_comb(input string pfx);
        predict();
        chk({pfx, "_stall"}, 32'(stall_DE), 32'(exp_stall));
        chk({pfx, "_issue"}, 32'(issue_DE), 32'(exp_issue));
        chk({pfx, "_flush"}, 32'(flush_DE), 32'(exp_flush));
    endtask

    // Advance the model across one posedge using the current inputs.
    task automatic model_step();
        int r;
        predict();
        if (wb_wr_reg && wb_rd != 0) begin
            r = int'(wb_rd);
            if (cnt_m[r] > 0) cnt_m[r]--;
            else err_m = 1;
        end
        if (exp_issue && de_wr_reg && de_rd != 0) cnt_m[int'(de_rd)]++;
        if (exp_issue && de_is_ctrl) pend_m = 1;
        else if (br_resolve) pend_m = 0;
        if (exp_stall && sc_m < 65535) sc_m++;
    endtask

    task automatic cycle(input string pfx);
        #1;
        check_comb(pfx);
        check_state(pfx);
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic randomize_inputs();
        de_valid    = ($urandom_range(0, 9) < 8);
        de_rs1      = 5'($urandom_range(0, 7));
        de_rs1_read = $urandom_range(0, 1);
        de_rs2      = 5'($urandom_range(0, 7));
        de_rs2_read = $urandom_range(0, 1);
        de_rd       = 5'($urandom_range(0, 7));
        de_wr_reg   = ($urandom_range(0, 3) != 0);
        de_is_ctrl  = ($urandom_range(0, 9) == 0);
        wb_wr_reg   = ($urandom_range(0, 9) < 4);
        wb_rd       = 5'($urandom_range(1, 7));
        if (pend_m != 0) br_resolve = ($urandom_range(0, 2) == 0);
        else br_resolve = ($urandom_range(0, 49) == 0);
        br_mispredict = $urandom_range(0, 1);
    endtask

    initial begin
        model_reset();
        idle_inputs();
        reset = 0;
        de_valid = 1;
        de_rs1 = 5; de_rs1_read = 1;
        #3;
        check_comb("rst");
        check_state("rst");
        @(negedge clk);
        reset = 1;
        idle_inputs();

        // Release of a register with nothing pending.
        wb_wr_reg = 1; wb_rd = 9;
        cycle("err");
        idle_inputs();
        cycle("err2");
        chk("err_sticky", 32'(sb_error), 32'd1);
        chk("err_cnt9", 32'(busy_regs[9]), 32'd0);

        for (int n = 0; n < 3000; n++) begin
            randomize_inputs();
            cycle("rnd");
        end

        // Asynchronous reset mid-run, away from any clock edge.
        randomize_inputs();
        #2;
        reset = 0;
        #1;
        model_reset();
        check_state("arst");
        idle_inputs();
        @(negedge clk);
        reset = 1;

        for (int n = 0; n < 1000; n++) begin
            randomize_inputs();
            cycle("rnd2");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
